i2c_csr_bridge: RTL and testbench

I2C_CSR_BRIDGE -- requirements
Module: i2c_csr_bridge

---
 rtl/i2c_csr_pkg.sv | 28 ++
 rtl/i2c_line_cond.sv | 90 +++++++++
 rtl/i2c_csr_bridge.sv | 197 +++++++++++++++++++
 tb/tb_i2c_csr_bridge.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_csr_pkg.sv
// i2c_csr_pkg: shared widths, FSM state encoding and helpers for the I2C CSR bridge.
// Optional feature macro used by this slice: I2C_GLITCH_FILTER_EN.
package i2c_csr_pkg;

  localparam int CSR_ADDR_W = 5;
  localparam int CSR_DATA_W = 8;
  localparam int BIT_CNT_W  = 4;
  localparam int ARM_CNT_W  = 3;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_t;

  // Two-out-of-three vote used by the optional line glitch filter.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: brings the raw SCL/SDA pins into the clk domain and detects
// SCL edges plus START/STOP bus conditions.
// Optional feature: define I2C_GLITCH_FILTER_EN to add a 3-sample majority
// filter behind each synchronizer (2 clk extra latency, clk >= 24x SCL).
module i2c_line_cond
  import i2c_csr_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0]           scl_sync;
  logic [1:0]           sda_sync;
  logic                 scl_c;
  logic                 sda_c;
  logic                 scl_prev;
  logic                 sda_prev;
  logic [ARM_CNT_W-1:0] arm_cnt;
  logic                 armed;

  // Two-flop synchronizers; reset to 1 so a reset looks like an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;
  logic       scl_flt;
  logic       sda_flt;

  // Majority vote over the current and two previous synchronized samples,
  // so a single-clk spike never reaches the edge detectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_flt  <= 1'b1;
      sda_flt  <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_flt  <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
      sda_flt  <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
    end
  end

  assign scl_c = scl_flt;
  assign sda_c = sda_flt;
`else
  assign scl_c = scl_sync[1];
  assign sda_c = sda_sync[1];
`endif

  // Previous conditioned levels for edge detection, plus a short arming delay
  // after reset so the pipeline refilling with real pin levels is not taken
  // for a bus event; only a fresh START afterwards is recognised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
      arm_cnt  <= '0;
    end else begin
      scl_prev <= scl_c;
      sda_prev <= sda_c;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign armed    = &arm_cnt;
  assign sda      = sda_c;
  assign scl_rise = armed &  scl_c & ~scl_prev;
  assign scl_fall = armed & ~scl_c &  scl_prev;
  assign start    = armed &  scl_c &  scl_prev &  sda_prev & ~sda_c;
  assign stop     = armed &  scl_c &  scl_prev & ~sda_prev &  sda_c;

endmodule

// File: rtl/i2c_csr_bridge.sv
// i2c_csr_bridge: I2C target that maps a 5-bit register pointer onto a simple
// CSR bus. First written byte sets the pointer, further written bytes are
// strobed out with csr_we, reads stream csr_do; the pointer auto-increments.
// Optional feature macro (in i2c_line_cond): I2C_GLITCH_FILTER_EN.
module i2c_csr_bridge
  import i2c_csr_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h4a
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [CSR_ADDR_W-1:0] csr_a,
  output logic [CSR_DATA_W-1:0] csr_di,
  output logic                  csr_we,
  input  logic [CSR_DATA_W-1:0] csr_do
);

  logic                  sda_c;
  logic                  scl_rise;
  logic                  scl_fall;
  logic                  start_det;
  logic                  stop_det;

  i2c_state_t            state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [CSR_DATA_W-1:0] shift;
  logic [CSR_DATA_W-1:0] rx_byte;
  logic [CSR_ADDR_W-1:0] ptr;
  logic                  rw_bit;
  logic                  nack;

  i2c_line_cond u_line_cond (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda_c),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_det),
    .stop     (stop_det)
  );

  assign rx_byte = {shift[CSR_DATA_W-2:0], sda_c};
  assign csr_a   = ptr;

  // Protocol FSM: bits are taken on SCL rise, SDA is only ever changed after
  // an SCL fall. In ACK states bit_cnt marks whether the ACK is being held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      ptr     <= '0;
      rw_bit  <= 1'b0;
      nack    <= 1'b0;
      sda_oe  <= 1'b0;
      csr_di  <= '0;
      csr_we  <= 1'b0;
    end else begin
      csr_we <= 1'b0;
      if (csr_we) ptr <= ptr + 1'b1;

      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (rx_byte[7:1] == I2C_ADDR) begin
                  rw_bit <= rx_byte[0];
                  state  <= ADDR_ACK;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_oe  <= 1'b1;
                bit_cnt <= 4'd1;
              end else begin
                bit_cnt <= '0;
                if (rw_bit) begin
                  state  <= RDATA;
                  shift  <= csr_do;
                  sda_oe <= ~csr_do[7];
                end else begin
                  state  <= PTR;
                  sda_oe <= 1'b0;
                end
              end
            end
          end

          PTR: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                ptr     <= rx_byte[CSR_ADDR_W-1:0];
                state   <= PTR_ACK;
              end
            end
          end

          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_oe  <= 1'b1;
                bit_cnt <= 4'd1;
              end else begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                state   <= WDATA;
              end
            end
          end

          WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                csr_di  <= rx_byte;
                csr_we  <= 1'b1;
                state   <= WDATA_ACK;
              end
            end
          end

          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                state   <= RDATA_ACK;
              end else begin
                shift  <= {shift[CSR_DATA_W-2:0], 1'b0};
                sda_oe <= ~shift[CSR_DATA_W-2];
              end
            end
          end

          RDATA_ACK: begin
            // The pointer advances on the ACK clock so csr_do already shows
            // the next register by the fall where it is loaded.
            if (scl_rise) begin
              nack    <= sda_c;
              ptr     <= ptr + 1'b1;
              bit_cnt <= 4'd1;
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt <= '0;
              if (nack) begin
                state <= IGNORE;
              end else begin
                state  <= RDATA;
                shift  <= csr_do;
                sda_oe <= ~csr_do[7];
              end
            end
          end

          IGNORE: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_csr_bridge.sv
// tb_i2c_csr_bridge: bus-level master driving the bridge, a CSR memory behind
// it, and a transaction-level model of register pointer and memory contents.
`timescale 1ns/1ps
module tb_i2c_csr_bridge;

  localparam int         QC       = 10;
  localparam logic [6:0] TGT_ADDR = 7'h4a;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  logic [7:0] csr_mem [32];
  logic       ld_en = 1'b0;
  logic [4:0] ld_a = '0;
  logic [7:0] ld_d = '0;

  logic [7:0]  model_mem [32];
  int          model_ptr = 0;
  logic [12:0] exp_q [$];
  logic [7:0]  tx_data [$];
  logic [7:0]  rd_got [$];
  logic        quiet = 1'b0;

  int checks = 0;
  int errors = 0;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  i2c_csr_bridge #(.I2C_ADDR(TGT_ADDR)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .scl_i  (scl_i),
    .sda_i  (sda_i),
    .sda_oe (sda_oe),
    .csr_a  (csr_a),
    .csr_di (csr_di),
    .csr_we (csr_we),
    .csr_do (csr_do)
  );

  always #5 clk = ~clk;

  // CSR block behind the bridge: written by the bridge, preloadable by the bench.
  always @(posedge clk) begin
    if (csr_we) csr_mem[csr_a] <= csr_di;
    else if (ld_en) csr_mem[ld_a] <= ld_d;
  end
  assign csr_do = csr_mem[csr_a];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle compare: every strobe must match the next predicted write, and
  // SDA must stay released whenever the model says the bridge is not addressed.
  always @(negedge clk) begin
    logic [12:0] e;
    if (rst_n) begin
      if (csr_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_we: got addr %0h data %0h, expected no write", csr_a, csr_di);
        end else begin
          e = exp_q.pop_front();
          checkOutput("we_addr", 32'(csr_a), 32'(e[12:8]));
          checkOutput("we_data", 32'(csr_di), 32'(e[7:0]));
        end
      end
      if (quiet) checkOutput("quiet_sda_oe", 32'(sda_oe), 32'd0);
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL timeout: simulation did not finish, expected end of stimulus");
    $fatal(1, "[TB] timeout");
  end

  task automatic waitQ();
    repeat (QC) @(negedge clk);
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    ld_a = 5'(a);
    ld_d = d;
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic clockBit(input logic b, output logic s);
    sda_m = b;
    waitQ();
    scl_m = 1'b1;
    waitQ();
    s = sda_i;
    waitQ();
    scl_m = 1'b0;
    waitQ();
  endtask

  task automatic busStart();
    sda_m = 1'b1;
    waitQ();
    scl_m = 1'b1;
    waitQ();
    sda_m = 1'b0;
    waitQ();
    scl_m = 1'b0;
    waitQ();
  endtask

  task automatic busStop();
    sda_m = 1'b0;
    waitQ();
    scl_m = 1'b1;
    waitQ();
    sda_m = 1'b1;
    waitQ();
    waitQ();
  endtask

  task automatic writeByte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(b[i], s);
    clockBit(1'b1, s);
    acked = ~s;
  endtask

  task automatic readByte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, s);
      b[i] = s;
    end
    clockBit(~ack, s);
  endtask

  // Addressed write: pointer byte then every byte in tx_data.
  task automatic txWrite(input logic [7:0] pb, input logic do_stop);
    logic acked;
    busStart();
    writeByte({TGT_ADDR, 1'b0}, acked);
    checkOutput("wr_addr_ack", 32'(acked), 32'd1);
    writeByte(pb, acked);
    checkOutput("wr_ptr_ack", 32'(acked), 32'd1);
    model_ptr = int'(pb) % 32;
    foreach (tx_data[k]) begin
      exp_q.push_back({5'(model_ptr), tx_data[k]});
      model_mem[model_ptr] = tx_data[k];
      model_ptr = (model_ptr + 1) % 32;
      writeByte(tx_data[k], acked);
      checkOutput("wr_data_ack", 32'(acked), 32'd1);
    end
    if (do_stop) busStop();
  endtask

  // Addressed read of n bytes from the current pointer, last one NACKed.
  task automatic txRead(input int n);
    logic       acked;
    logic [7:0] b;
    rd_got.delete();
    busStart();
    writeByte({TGT_ADDR, 1'b1}, acked);
    checkOutput("rd_addr_ack", 32'(acked), 32'd1);
    for (int k = 0; k < n; k++) begin
      readByte(k < n - 1, b);
      rd_got.push_back(b);
      checkOutput("rd_data", 32'(b), 32'(model_mem[model_ptr]));
      model_ptr = (model_ptr + 1) % 32;
    end
    busStop();
  endtask

  // Transaction to some other target: nothing may answer.
  task automatic txMismatch(input logic [6:0] a, input logic rw);
    logic acked;
    quiet = 1'b1;
    busStart();
    writeByte({a, rw}, acked);
    checkOutput("mm_addr_nack", 32'(acked), 32'd0);
    writeByte(8'($urandom), acked);
    checkOutput("mm_data_nack", 32'(acked), 32'd0);
    busStop();
    quiet = 1'b0;
  endtask

`ifdef I2C_GLITCH_FILTER_EN
  // Byte write with a one-clk SCL spike in the low phase of bit 4.
  task automatic writeByteGlitch(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      if (i == 4) begin
        repeat (QC / 2) @(negedge clk);
        scl_m = 1'b1;
        @(negedge clk);
        scl_m = 1'b0;
        repeat (QC / 2 - 1) @(negedge clk);
      end else begin
        waitQ();
      end
      scl_m = 1'b1;
      waitQ();
      waitQ();
      scl_m = 1'b0;
      waitQ();
    end
    clockBit(1'b1, s);
    acked = ~s;
  endtask
`endif

  // Randomized traffic mix checked against the transaction model.
  task automatic applyStimulus(input int n_tx);
    int         kind;
    int         n;
    logic [6:0] a;
    for (int t = 0; t < n_tx; t++) begin
      kind = int'($urandom_range(0, 3));
      tx_data.delete();
      case (kind)
        0: begin
          n = int'($urandom_range(0, 3));
          for (int k = 0; k < n; k++) tx_data.push_back(8'($urandom));
          txWrite(8'($urandom), 1'b1);
        end
        1: begin
          txWrite(8'($urandom), 1'b0);
          txRead(int'($urandom_range(1, 3)));
        end
        2: txRead(int'($urandom_range(1, 3)));
        default: begin
          do a = 7'($urandom); while (a == TGT_ADDR);
          txMismatch(a, 1'($urandom));
        end
      endcase
      checkOutput("tx_csr_a", 32'(csr_a), 32'(model_ptr));
    end
  endtask

  initial begin
    logic s;
    logic acked;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("rst_csr_we", 32'(csr_we), 32'd0);
    checkOutput("rst_csr_a", 32'(csr_a), 32'd0);
    checkOutput("rst_csr_di", 32'(csr_di), 32'd0);
    for (int i = 0; i < 32; i++) preload(i, 8'($urandom));
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Single write to register 3.
    tx_data.delete();
    tx_data.push_back(8'h5A);
    txWrite(8'h03, 1'b1);
    checkOutput("w_mem3", 32'(csr_mem[3]), 32'h5A);
    checkOutput("w_ptr", 32'(csr_a), 32'd4);

    // Write pointer, repeated START, read two bytes.
    preload(3, 8'hC3);
    preload(4, 8'h3C);
    tx_data.delete();
    txWrite(8'h03, 1'b0);
    txRead(2);
    checkOutput("r_byte0", 32'(rd_got[0]), 32'hC3);
    checkOutput("r_byte1", 32'(rd_got[1]), 32'h3C);
    checkOutput("r_ptr", 32'(csr_a), 32'd5);

    // Pointer wrap 31 -> 0.
    tx_data.delete();
    tx_data.push_back(8'h11);
    tx_data.push_back(8'h22);
    txWrite(8'h1F, 1'b1);
    checkOutput("wrap_mem31", 32'(csr_mem[31]), 32'h11);
    checkOutput("wrap_mem0", 32'(csr_mem[0]), 32'h22);
    checkOutput("wrap_ptr", 32'(csr_a), 32'd1);

    // Foreign address 0x96 and the general call.
    txMismatch(7'h4b, 1'b0);
    txMismatch(7'h00, 1'b0);
    checkOutput("mm_ptr", 32'(csr_a), 32'd1);

    // STOP after four data bits: partial byte dropped.
    busStart();
    writeByte({TGT_ADDR, 1'b0}, acked);
    checkOutput("ab_addr_ack", 32'(acked), 32'd1);
    writeByte(8'h07, acked);
    checkOutput("ab_ptr_ack", 32'(acked), 32'd1);
    model_ptr = 7;
    for (int i = 0; i < 4; i++) clockBit(1'($urandom), s);
    busStop();
    checkOutput("ab_ptr", 32'(csr_a), 32'd7);

    // Reset while the bridge holds an ACK: SDA must let go at once.
    busStart();
    for (int i = 7; i >= 0; i--) clockBit(TGT_ADDR_W0(i), s);
    sda_m = 1'b1;
    waitQ();
    checkOutput("ab_ack_held", 32'(sda_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("ab_rst_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("ab_rst_csr_a", 32'(csr_a), 32'd0);
    model_ptr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 18; i++) clockBit(1'b0, s);
    busStop();
    quiet = 1'b0;
    checkOutput("ab_after_ptr", 32'(csr_a), 32'd0);

`ifdef I2C_GLITCH_FILTER_EN
    // SCL spike mid-byte must not add a bit.
    busStart();
    writeByte({TGT_ADDR, 1'b0}, acked);
    writeByte(8'h0A, acked);
    model_ptr = 10;
    exp_q.push_back({5'd10, 8'hA5});
    model_mem[10] = 8'hA5;
    model_ptr = 11;
    writeByteGlitch(8'hA5, acked);
    checkOutput("gl_ack", 32'(acked), 32'd1);
    busStop();
    checkOutput("gl_mem", 32'(csr_mem[10]), 32'hA5);
    checkOutput("gl_ptr", 32'(csr_a), 32'd11);
`endif

    applyStimulus(20);

    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bit i of the write address byte for the target.
  function automatic logic TGT_ADDR_W0(input int i);
    logic [7:0] b;
    b = {TGT_ADDR, 1'b0};
    return b[i];
  endfunction

endmodule
